// File: rtl/fibonacci_index_decoder.sv
// rtl/fibonacci_index_decoder.sv - Fibonacci membership and index search for a 32-bit value
// Regenerates F(k) from F(0) until it matches or passes the captured value.
module fibonacci_index_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        is_fib,
  output logic [5:0]  n
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] target, target_nx;
  logic [32:0] a, a_nx;
  logic [32:0] b, b_nx;
  logic [5:0]  k, k_nx;
  logic        is_fib_nx;
  logic [5:0]  n_nx;
  logic [32:0] target_ext;

  assign target_ext = {1'b0, target};

  always_comb begin
    state_nx  = state;
    target_nx = target;
    a_nx      = a;
    b_nx      = b;
    k_nx      = k;
    is_fib_nx = is_fib;
    n_nx      = n;
    case (state)
      IDLE: begin
        if (start) begin
          target_nx = value;
          a_nx      = 33'd0;
          b_nx      = 33'd1;
          k_nx      = 6'd0;
          state_nx  = SEARCH;
        end
      end
      SEARCH: begin
        // F(48) exceeds every 32-bit value, so k never passes 48 here
        if (a == target_ext) begin
          is_fib_nx = 1'b1;
          n_nx      = k;
          state_nx  = DONE;
        end else if (a > target_ext) begin
          is_fib_nx = 1'b0;
          n_nx      = k;
          state_nx  = DONE;
        end else begin
          a_nx = b;
          b_nx = a + b;
          k_nx = k + 6'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      target <= 32'd0;
      a      <= 33'd0;
      b      <= 33'd0;
      k      <= 6'd0;
      is_fib <= 1'b0;
      n      <= 6'd0;
    end else begin
      state  <= state_nx;
      target <= target_nx;
      a      <= a_nx;
      b      <= b_nx;
      k      <= k_nx;
      is_fib <= is_fib_nx;
      n      <= n_nx;
    end
  end

  // Both decode the state register directly, so they cannot overlap
  assign busy = (state == SEARCH);
  assign done = (state == DONE);

endmodule
